alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU core interface. It accepts one ALU command (opcode, two 8-bit operands) from the instruction decode stage over a valid/ready handshake. It drives the ALU core's enable/opcode/opA/opB lines for a fixed settle window, then captures the 16-bit core result. It returns that result with status flags to the writeback stage over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles alu_enable is held before core_out is captured (legal range 1..15)
OPW, 8, operand width
RESW, 16, result width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  block can accept a command
cmd_opcode  in  4  ALU opcode
cmd_opa  in  OPW  operand A
cmd_opb  in  OPW  operand B
alu_enable  out  1  to ALU core enable
alu_opcode  out  4  to ALU core opcode
alu_opa  out  OPW  to ALU core opA
alu_opb  out  OPW  to ALU core opB
alu_result  in  RESW  from ALU core core_out
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  RESW  captured result
res_zero  out  1  res_data == 0
res_neg  out  1  res_data[RESW-1]
res_err  out  1  opcode was unsupported (4'b1100..4'b1111)
busy  out  1  state != IDLE
op_count  out  16  completed results handed off, wraps 0xFFFF->0x0000

Behaviour:
- Reset, asynchronous with rst_n=0:
  - state=IDLE; all outputs 0; cmd_ready=1 once rst_n=1.
  - Any in-flight command or held result is discarded.
- States are IDLE, DRIVE, RESULT.
- IDLE:
  - cmd_ready=1.
  - On a clock edge with cmd_valid&cmd_ready: register opcode/opa/opb into alu_opcode/alu_opa/alu_opb, load the settle counter with SETTLE_CYCLES-1, go to DRIVE.
- DRIVE:
  - alu_enable=1 for valid opcodes (0000..1011), 0 for unsupported opcodes.
  - cmd_ready=0.
  - The counter decrements each cycle. On the edge where it equals 0, go to RESULT and capture:
    - valid opcode: res_data=alu_result, res_err=0
    - unsupported opcode: res_data=0, res_err=1
  - Latency: res_valid rises exactly SETTLE_CYCLES cycles after the accepting edge, for every opcode.
- RESULT:
  - res_valid=1.
  - alu_enable=0, but alu_opcode/opa/opb are held stable.
  - res_data/res_zero/res_neg/res_err stay stable until the handshake completes.
  - cmd_ready = res_ready.
  - On res_valid&res_ready: op_count increments.
    - If cmd_valid is also high, the new command is accepted on the same edge and the state goes to DRIVE (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- Flags are computed from the captured value and registered with res_data.
- A cmd_valid held while busy (and not in the RESULT-handoff case) is not accepted. Upstream holds it.
- alu_opa/alu_opb are raw bit vectors. Sign interpretation belongs to the core.
- Reset asserted mid-DRIVE or mid-RESULT: the result is lost, op_count is cleared, and nothing is reported.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ANDM=4'b0000, OP_NAND, OP_NOR, OP_XOR, OP_NOT, OP_ADD, OP_SUB, OP_NEG, OP_SHL, OP_SHR, OP_ROL, OP_ROR=4'b1011
  - OP_LAST_VALID
  - the state encoding (IDLE=2'd0, DRIVE=2'd1, RESULT=2'd2)
- No sub-module. The settle counter and flag logic are inline. The bench instantiates the existing ALU core as the responder.

Test Plan:
1. SETTLE=1, cmd ADD (0101) opa=0x05 opb=0x03 -> res_valid 1 cycle after accept; res_data=0x0008, zero=0, neg=0, err=0; op_count=1.
2. SUB opa=0x03 opb=0x05 -> res_data=0xFFFE, neg=1. Then XOR opa=0x5A opb=0x5A -> res_data=0x0000, zero=1.
3. Opcode 0xC, any operands -> alu_enable never asserts; res_err=1, res_data=0x0000, same latency as a valid op.
4. res_ready held low 5 cycles in RESULT, with cmd_valid=1 -> res_valid/res_data stable, cmd_ready=0, no second accept. On res_ready=1 the next command is accepted the same edge, state goes to DRIVE, op_count increments by 1.
5. SETTLE_CYCLES=3, NEG (0111) opa=0x01 -> alu_enable high exactly 3 cycles; res_data=0xFFFF.
6. rst_n pulsed low in the middle of DRIVE -> immediately: busy=0, alu_enable=0, res_valid=0, op_count=0. After release, a new command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU core interface: opcodes, widths and the
// issue controller state encoding.
package alu_pkg;

    localparam int unsigned ALU_OPW  = 8;
    localparam int unsigned ALU_RESW = 16;
    localparam int unsigned OPCW     = 4;

    typedef logic [OPCW-1:0] opcode_t;

    localparam opcode_t OP_ANDM = 4'b0000;
    localparam opcode_t OP_NAND = 4'b0001;
    localparam opcode_t OP_NOR  = 4'b0010;
    localparam opcode_t OP_XOR  = 4'b0011;
    localparam opcode_t OP_NOT  = 4'b0100;
    localparam opcode_t OP_ADD  = 4'b0101;
    localparam opcode_t OP_SUB  = 4'b0110;
    localparam opcode_t OP_NEG  = 4'b0111;
    localparam opcode_t OP_SHL  = 4'b1000;
    localparam opcode_t OP_SHR  = 4'b1001;
    localparam opcode_t OP_ROL  = 4'b1010;
    localparam opcode_t OP_ROR  = 4'b1011;

    localparam opcode_t OP_LAST_VALID = OP_ROR;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Opcodes above OP_LAST_VALID are never shown to the core.
    function automatic logic op_supported(input opcode_t op);
        return op <= OP_LAST_VALID;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded command to the ALU core, waits a fixed settle window,
// captures the core result with status flags and hands it to writeback.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned OPW           = ALU_OPW,
    parameter int unsigned RESW          = ALU_RESW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_opcode,
    input  logic [OPW-1:0]  cmd_opa,
    input  logic [OPW-1:0]  cmd_opb,
    output logic            alu_enable,
    output logic [3:0]      alu_opcode,
    output logic [OPW-1:0]  alu_opa,
    output logic [OPW-1:0]  alu_opb,
    input  logic [RESW-1:0] alu_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RESW-1:0] res_data,
    output logic            res_zero,
    output logic            res_neg,
    output logic            res_err,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam int unsigned CNTW = 4;

    state_t          state_q,      state_d;
    logic [CNTW-1:0] cnt_q,        cnt_d;
    logic            alu_enable_q, alu_enable_d;
    opcode_t         alu_opcode_q, alu_opcode_d;
    logic [OPW-1:0]  alu_opa_q,    alu_opa_d;
    logic [OPW-1:0]  alu_opb_q,    alu_opb_d;
    logic [RESW-1:0] res_data_q,   res_data_d;
    logic            res_zero_q,   res_zero_d;
    logic            res_neg_q,    res_neg_d;
    logic            res_err_q,    res_err_d;
    logic [15:0]     op_count_q,   op_count_d;
    logic [RESW-1:0] capt;
    logic            accept;

    // Ready is combinational on res_ready so a handoff can accept the next command.
    assign cmd_ready = rst_n && ((state_q == IDLE) || ((state_q == RESULT) && res_ready));
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_enable_d = alu_enable_q;
        alu_opcode_d = alu_opcode_q;
        alu_opa_d    = alu_opa_q;
        alu_opb_d    = alu_opb_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        res_neg_d    = res_neg_q;
        res_err_d    = res_err_q;
        op_count_d   = op_count_q;
        capt         = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = DRIVE;
                    cnt_d        = CNTW'(SETTLE_CYCLES - 1);
                    alu_enable_d = op_supported(cmd_opcode);
                    alu_opcode_d = cmd_opcode;
                    alu_opa_d    = cmd_opa;
                    alu_opb_d    = cmd_opb;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    // Unsupported opcodes report zero with err, at the same latency.
                    if (op_supported(alu_opcode_q)) begin
                        capt      = alu_result;
                        res_err_d = 1'b0;
                    end else begin
                        capt      = '0;
                        res_err_d = 1'b1;
                    end
                    state_d      = RESULT;
                    alu_enable_d = 1'b0;
                    res_data_d   = capt;
                    res_zero_d   = (capt == '0);
                    res_neg_d    = capt[RESW-1];
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    if (accept) begin
                        state_d      = DRIVE;
                        cnt_d        = CNTW'(SETTLE_CYCLES - 1);
                        alu_enable_d = op_supported(cmd_opcode);
                        alu_opcode_d = cmd_opcode;
                        alu_opa_d    = cmd_opa;
                        alu_opb_d    = cmd_opb;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_enable_q <= 1'b0;
            alu_opcode_q <= '0;
            alu_opa_q    <= '0;
            alu_opb_q    <= '0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b0;
            res_neg_q    <= 1'b0;
            res_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_enable_q <= alu_enable_d;
            alu_opcode_q <= alu_opcode_d;
            alu_opa_q    <= alu_opa_d;
            alu_opb_q    <= alu_opb_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_neg_q    <= res_neg_d;
            res_err_q    <= res_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_enable = alu_enable_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_opa    = alu_opa_q;
    assign alu_opb    = alu_opb_q;
    assign res_valid  = (state_q == RESULT);
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_neg    = res_neg_q;
    assign res_err    = res_err_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench: two controllers (settle 1 and settle 3) each driving a
// behavioural ALU core responder.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n      [2];
    logic        cmd_valid  [2];
    logic        cmd_ready  [2];
    logic [3:0]  cmd_opcode [2];
    logic [7:0]  cmd_opa    [2];
    logic [7:0]  cmd_opb    [2];
    logic        alu_enable [2];
    logic [3:0]  alu_opcode [2];
    logic [7:0]  alu_opa    [2];
    logic [7:0]  alu_opb    [2];
    logic [15:0] alu_result [2];
    logic        res_valid  [2];
    logic        res_ready  [2];
    logic [15:0] res_data   [2];
    logic        res_zero   [2];
    logic        res_neg    [2];
    logic        res_err    [2];
    logic        busy       [2];
    logic [15:0] op_count   [2];

    int          vectors;
    int          miscompares;
    logic [15:0] exp_cnt [2];

    alu_issue_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_opcode(cmd_opcode[0]), .cmd_opa(cmd_opa[0]), .cmd_opb(cmd_opb[0]),
        .alu_enable(alu_enable[0]), .alu_opcode(alu_opcode[0]),
        .alu_opa(alu_opa[0]), .alu_opb(alu_opb[0]), .alu_result(alu_result[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .res_zero(res_zero[0]), .res_neg(res_neg[0]), .res_err(res_err[0]),
        .busy(busy[0]), .op_count(op_count[0])
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_opcode(cmd_opcode[1]), .cmd_opa(cmd_opa[1]), .cmd_opb(cmd_opb[1]),
        .alu_enable(alu_enable[1]), .alu_opcode(alu_opcode[1]),
        .alu_opa(alu_opa[1]), .alu_opb(alu_opb[1]), .alu_result(alu_result[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .res_zero(res_zero[1]), .res_neg(res_neg[1]), .res_err(res_err[1]),
        .busy(busy[1]), .op_count(op_count[1])
    );

    // Behavioural core: logic ops zero-extended, arithmetic sign-extended, junk when disabled.
    function automatic logic [15:0] alu_core(input logic en, input logic [3:0] op,
                                             input logic [7:0] a, input logic [7:0] b);
        logic [15:0] sa;
        logic [15:0] sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        if (!en) return 16'hDEAD;
        case (op)
            4'd0:    return {8'h00, a & b};
            4'd1:    return {8'h00, ~(a & b)};
            4'd2:    return {8'h00, ~(a | b)};
            4'd3:    return {8'h00, a ^ b};
            4'd4:    return {8'h00, ~a};
            4'd5:    return sa + sb;
            4'd6:    return sa - sb;
            4'd7:    return 16'd0 - sa;
            4'd8:    return {7'h00, a, 1'b0};
            4'd9:    return {8'h00, a >> 1};
            4'd10:   return {8'h00, a[6:0], a[7]};
            4'd11:   return {8'h00, a[0], a[7:1]};
            default: return 16'hBAD0;
        endcase
    endfunction

    assign alu_result[0] = alu_core(alu_enable[0], alu_opcode[0], alu_opa[0], alu_opb[0]);
    assign alu_result[1] = alu_core(alu_enable[1], alu_opcode[1], alu_opa[1], alu_opb[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int d, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid[d]  = 1'b1;
        cmd_opcode[d] = op;
        cmd_opa[d]    = a;
        cmd_opb[d]    = b;
        tick();
        cmd_valid[d]  = 1'b0;
    endtask

    // Called right after the accepting edge; latency counts edges until res_valid.
    task automatic wait_result(input int d, output int lat, output int en_cnt);
        lat    = 0;
        en_cnt = alu_enable[d] ? 1 : 0;
        while (!res_valid[d] && lat < 20) begin
            tick();
            lat++;
            if (alu_enable[d]) en_cnt++;
        end
    endtask

    task automatic handoff(input int d);
        res_ready[d] = 1'b1;
        tick();
        res_ready[d] = 1'b0;
        exp_cnt[d]   = exp_cnt[d] + 16'd1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; res_ready[d] = 1'b0;
            cmd_opcode[d] = 4'h0; cmd_opa[d] = 8'h00; cmd_opb[d] = 8'h00;
            exp_cnt[d] = 16'd0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({cmd_ready[d], busy[d], res_valid[d], alu_enable[d], res_err[d], res_zero[d],
                 res_neg[d], op_count[d], res_data[d], alu_opcode[d], alu_opa[d], alu_opb[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d got rdy=%b busy=%b rv=%b en=%b cnt=%h data=%h exp all 0",
                         d, cmd_ready[d], busy[d], res_valid[d], alu_enable[d], op_count[d], res_data[d]);
            end
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release dut%0d got rdy=%b busy=%b exp rdy=1 busy=0", d, cmd_ready[d], busy[d]);
            end
        end
    endtask

    task automatic test_add();
        int lat, en;
        start_cmd(0, 4'b0101, 8'h05, 8'h03);
        vectors++;
        if (alu_enable[0] !== 1'b1 || busy[0] !== 1'b1 || cmd_ready[0] !== 1'b0 || res_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL add_drive got en=%b busy=%b rdy=%b rv=%b exp 1 1 0 0",
                     alu_enable[0], busy[0], cmd_ready[0], res_valid[0]);
        end
        wait_result(0, lat, en);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL add_latency got %0d exp 1", lat);
        end
        vectors++;
        if ({res_data[0], res_zero[0], res_neg[0], res_err[0]} !== {16'h0008, 3'b000}) begin
            miscompares++;
            $display("FAIL add_result got data=%h z=%b n=%b e=%b exp 0008 0 0 0",
                     res_data[0], res_zero[0], res_neg[0], res_err[0]);
        end
        vectors++;
        if (cmd_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL add_ready_stall got %b exp 0", cmd_ready[0]);
        end
        handoff(0);
        vectors++;
        if (op_count[0] !== exp_cnt[0] || op_count[0] !== 16'd1 || res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL add_handoff got cnt=%h rv=%b busy=%b exp cnt=0001 rv=0 busy=0",
                     op_count[0], res_valid[0], busy[0]);
        end
    endtask

    task automatic test_sub_xor();
        int lat, en;
        start_cmd(0, 4'b0110, 8'h03, 8'h05);
        wait_result(0, lat, en);
        vectors++;
        if ({res_data[0], res_zero[0], res_neg[0], res_err[0]} !== {16'hFFFE, 3'b010}) begin
            miscompares++;
            $display("FAIL sub_result got data=%h z=%b n=%b e=%b exp FFFE 0 1 0",
                     res_data[0], res_zero[0], res_neg[0], res_err[0]);
        end
        handoff(0);
        start_cmd(0, 4'b0011, 8'h5A, 8'h5A);
        wait_result(0, lat, en);
        vectors++;
        if ({res_data[0], res_zero[0], res_neg[0], res_err[0]} !== {16'h0000, 3'b100}) begin
            miscompares++;
            $display("FAIL xor_result got data=%h z=%b n=%b e=%b exp 0000 1 0 0",
                     res_data[0], res_zero[0], res_neg[0], res_err[0]);
        end
        handoff(0);
        vectors++;
        if (op_count[0] !== exp_cnt[0]) begin
            miscompares++;
            $display("FAIL sub_xor_count got %h exp %h", op_count[0], exp_cnt[0]);
        end
    endtask

    task automatic test_unsupported();
        int lat, en;
        start_cmd(0, 4'hC, 8'hFF, 8'hFF);
        wait_result(0, lat, en);
        vectors++;
        if (lat !== 1 || en !== 0) begin
            miscompares++;
            $display("FAIL bad_op_timing got lat=%0d en_cycles=%0d exp lat=1 en_cycles=0", lat, en);
        end
        vectors++;
        if ({res_data[0], res_err[0], res_zero[0], res_neg[0]} !== {16'h0000, 3'b110}) begin
            miscompares++;
            $display("FAIL bad_op_result got data=%h e=%b z=%b n=%b exp 0000 1 1 0",
                     res_data[0], res_err[0], res_zero[0], res_neg[0]);
        end
        handoff(0);
    endtask

    task automatic test_back_to_back();
        int lat, en;
        int bad;
        start_cmd(0, 4'b0000, 8'hF0, 8'h3C);
        wait_result(0, lat, en);
        cmd_valid[0] = 1'b1; cmd_opcode[0] = 4'b0101; cmd_opa[0] = 8'h7F; cmd_opb[0] = 8'h01;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid[0] !== 1'b1 || res_data[0] !== 16'h0030 || cmd_ready[0] !== 1'b0 ||
                alu_opa[0] !== 8'hF0 || alu_enable[0] !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold got %0d bad cycles (rv=%b data=%h rdy=%b opa=%h) exp 0",
                     bad, res_valid[0], res_data[0], cmd_ready[0], alu_opa[0]);
        end
        res_ready[0] = 1'b1;
        #1;
        vectors++;
        if (cmd_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff_ready got %b exp 1", cmd_ready[0]);
        end
        tick();
        res_ready[0] = 1'b0;
        cmd_valid[0] = 1'b0;
        exp_cnt[0]   = exp_cnt[0] + 16'd1;
        vectors++;
        if (busy[0] !== 1'b1 || res_valid[0] !== 1'b0 || alu_enable[0] !== 1'b1 ||
            alu_opa[0] !== 8'h7F || op_count[0] !== exp_cnt[0]) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b rv=%b en=%b opa=%h cnt=%h exp 1 0 1 7f %h",
                     busy[0], res_valid[0], alu_enable[0], alu_opa[0], op_count[0], exp_cnt[0]);
        end
        wait_result(0, lat, en);
        vectors++;
        if (lat !== 1 || res_data[0] !== 16'h0080 || res_neg[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result got lat=%0d data=%h n=%b exp 1 0080 0", lat, res_data[0], res_neg[0]);
        end
        handoff(0);
        vectors++;
        if (op_count[0] !== exp_cnt[0] || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count got cnt=%h busy=%b exp %h 0", op_count[0], busy[0], exp_cnt[0]);
        end
    endtask

    task automatic test_settle3();
        int lat, en;
        start_cmd(1, 4'b0111, 8'h01, 8'h00);
        wait_result(1, lat, en);
        vectors++;
        if (lat !== 3 || en !== 3) begin
            miscompares++;
            $display("FAIL settle3_timing got lat=%0d en_cycles=%0d exp 3 3", lat, en);
        end
        vectors++;
        if ({res_data[1], res_zero[1], res_neg[1], res_err[1]} !== {16'hFFFF, 3'b010}) begin
            miscompares++;
            $display("FAIL settle3_result got data=%h z=%b n=%b e=%b exp FFFF 0 1 0",
                     res_data[1], res_zero[1], res_neg[1], res_err[1]);
        end
        handoff(1);
        vectors++;
        if (op_count[1] !== 16'd1) begin
            miscompares++;
            $display("FAIL settle3_count got %h exp 0001", op_count[1]);
        end
    endtask

    task automatic test_reset_mid_drive();
        int lat, en;
        start_cmd(1, 4'b0101, 8'h01, 8'h01);
        tick();
        rst_n[1] = 1'b0;
        #1;
        vectors++;
        if (busy[1] !== 1'b0 || alu_enable[1] !== 1'b0 || res_valid[1] !== 1'b0 || op_count[1] !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b en=%b rv=%b cnt=%h exp 0 0 0 0000",
                     busy[1], alu_enable[1], res_valid[1], op_count[1]);
        end
        exp_cnt[1] = 16'd0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        tick();
        start_cmd(1, 4'b0101, 8'h02, 8'h02);
        wait_result(1, lat, en);
        vectors++;
        if (lat !== 3 || res_data[1] !== 16'h0004) begin
            miscompares++;
            $display("FAIL post_reset_result got lat=%0d data=%h exp 3 0004", lat, res_data[1]);
        end
        handoff(1);
        vectors++;
        if (op_count[1] !== exp_cnt[1] || op_count[1] !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_count got %h exp 0001", op_count[1]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_sub_xor();
        test_unsupported();
        test_back_to_back();
        test_settle3();
        test_reset_mid_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
